promediador_muestras: RTL and testbench

- Consumes 12-bit ADC samples from the SPI conversion stage: `datos`, plus a `ready` flag that rises once per conversion.
- Averages each window of 2^LOG2_N samples into one 12-bit signed result.
- Presents the result to the downstream consumer with a valid/ack handshake.
- Optionally tracks per-window minimum and maximum.

---
 rtl/promediador_muestras.sv | 118 +++++++++++
 tb/tb_promediador_muestras.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/promediador_muestras.sv
// Windowed averager for 12-bit signed ADC samples with a valid/ack result port.
// Define PROMEDIO_MINMAX_EN to add per-window minimum/maximum outputs.
module promediador_muestras #(
    parameter int LOG2_N = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        habilitar,
    input  logic [11:0] datos,
    input  logic        ready,
    output logic [11:0] promedio,
    output logic        promedio_valido,
    input  logic        promedio_ack,
    output logic        sobrecarga
`ifdef PROMEDIO_MINMAX_EN
    ,
    output logic [11:0] minimo,
    output logic [11:0] maximo
`endif
);

    localparam int ACC_W = 12 + LOG2_N;
    localparam int CNT_W = LOG2_N + 1;
    localparam logic [CNT_W-1:0] ULTIMA = CNT_W'((1 << LOG2_N) - 1);

    typedef enum logic {ACUM, SALIDA} estado_t;

    estado_t                 estado;
    logic                    ready_d;
    logic                    evento;
    logic signed [ACC_W-1:0] acum;
    logic signed [ACC_W-1:0] datos_ext;
    logic [CNT_W-1:0]        cuenta;

    // ready stays high for many clocks, so only its rising edge is a sample
    assign evento    = ready & ~ready_d;
    assign datos_ext = ACC_W'($signed(datos));

`ifdef PROMEDIO_MINMAX_EN
    logic signed [11:0] min_run;
    logic signed [11:0] max_run;
    logic signed [11:0] datos_s;

    assign datos_s = $signed(datos);
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            estado          <= ACUM;
            ready_d         <= 1'b1;
            acum            <= '0;
            cuenta          <= '0;
            promedio        <= '0;
            promedio_valido <= 1'b0;
            sobrecarga      <= 1'b0;
`ifdef PROMEDIO_MINMAX_EN
            min_run         <= '0;
            max_run         <= '0;
            minimo          <= '0;
            maximo          <= '0;
`endif
        end else begin
            ready_d <= ready;

            // A load in SALIDA below overrides this clear when both coincide
            if (promedio_valido && promedio_ack) begin
                promedio_valido <= 1'b0;
            end

            if (!habilitar) begin
                estado  <= ACUM;
                acum    <= '0;
                cuenta  <= '0;
`ifdef PROMEDIO_MINMAX_EN
                min_run <= '0;
                max_run <= '0;
`endif
            end else begin
                case (estado)
                    ACUM: begin
                        if (evento) begin
                            acum   <= acum + datos_ext;
                            cuenta <= cuenta + CNT_W'(1);
`ifdef PROMEDIO_MINMAX_EN
                            if (cuenta == '0) begin
                                min_run <= datos_s;
                                max_run <= datos_s;
                            end else begin
                                if (datos_s < min_run) min_run <= datos_s;
                                if (datos_s > max_run) max_run <= datos_s;
                            end
`endif
                            if (cuenta == ULTIMA) begin
                                estado <= SALIDA;
                            end
                        end
                    end
                    SALIDA: begin
                        promedio        <= 12'(acum >>> LOG2_N);
                        promedio_valido <= 1'b1;
                        acum            <= '0;
                        cuenta          <= '0;
                        if (promedio_valido && !promedio_ack) begin
                            sobrecarga <= 1'b1;
                        end
`ifdef PROMEDIO_MINMAX_EN
                        minimo          <= min_run;
                        maximo          <= max_run;
`endif
                        estado          <= ACUM;
                    end
                    default: estado <= ACUM;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_promediador_muestras.sv
// Directed bench for promediador_muestras: queue-based window model checked every cycle,
// plus literal expectations. Covers the min/max outputs when PROMEDIO_MINMAX_EN is defined.
module tb_promediador_muestras;

    localparam int LOG2_N = 2;
    localparam int NWIN   = 1 << LOG2_N;

    logic        clock;
    logic        reset_n;
    logic        habilitar;
    logic [11:0] datos;
    logic        ready;
    logic [11:0] promedio;
    logic        promedio_valido;
    logic        promedio_ack;
    logic        sobrecarga;
    logic [11:0] datos0;
    logic        ready0;
    logic [11:0] promedio0;
    logic        valido0;
    logic        ack0;
    logic        sob0;
`ifdef PROMEDIO_MINMAX_EN
    logic [11:0] minimo;
    logic [11:0] maximo;
    logic [11:0] minimo0;
    logic [11:0] maximo0;
`endif

    int total = 0;
    int bad   = 0;
    bit checking = 0;

    promediador_muestras #(.LOG2_N(LOG2_N)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .habilitar(habilitar),
        .datos(datos),
        .ready(ready),
        .promedio(promedio),
        .promedio_valido(promedio_valido),
        .promedio_ack(promedio_ack),
        .sobrecarga(sobrecarga)
`ifdef PROMEDIO_MINMAX_EN
        ,
        .minimo(minimo),
        .maximo(maximo)
`endif
    );

    promediador_muestras #(.LOG2_N(0)) dut0 (
        .clock(clock),
        .reset_n(reset_n),
        .habilitar(habilitar),
        .datos(datos0),
        .ready(ready0),
        .promedio(promedio0),
        .promedio_valido(valido0),
        .promedio_ack(ack0),
        .sobrecarga(sob0)
`ifdef PROMEDIO_MINMAX_EN
        ,
        .minimo(minimo0),
        .maximo(maximo0)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk12(input string name, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: windows as a queue of sample values, average by floor division
    int m_prom, m_min, m_max;
    bit m_valid, m_sob, pending, was_pend, prev_ready;
    int win[$];
    int suma;

    function automatic int floor_avg(input int s);
        if (s >= 0) return s / NWIN;
        return -((-s + NWIN - 1) / NWIN);
    endfunction

    always @(posedge clock) begin
        if (!reset_n) begin
            m_prom = 0; m_min = 0; m_max = 0;
            m_valid = 0; m_sob = 0; pending = 0; prev_ready = 1;
            win.delete();
        end else begin
            was_pend = pending;
            pending  = 0;
            if (was_pend && habilitar) begin
                suma  = 0;
                m_min = win[0];
                m_max = win[0];
                foreach (win[i]) begin
                    suma += win[i];
                    if (win[i] < m_min) m_min = win[i];
                    if (win[i] > m_max) m_max = win[i];
                end
                m_prom = floor_avg(suma);
                if (m_valid && !promedio_ack) m_sob = 1;
                m_valid = 1;
                win.delete();
                $display("window result %0d", m_prom);
            end else if (m_valid && promedio_ack) begin
                m_valid = 0;
            end
            if (!habilitar) begin
                win.delete();
            end else if (ready && !prev_ready && !was_pend) begin
                win.push_back(int'($signed(datos)));
                if (win.size() == NWIN) pending = 1;
            end
            prev_ready = ready;
        end
    end

    always @(negedge clock) begin
        if (checking) begin
            chk12("promedio", promedio, 12'(m_prom));
            chk1("valido", promedio_valido, m_valid);
            chk1("sobrecarga", sobrecarga, m_sob);
`ifdef PROMEDIO_MINMAX_EN
            chk12("minimo", minimo, 12'(m_min));
            chk12("maximo", maximo, 12'(m_max));
`endif
        end
    end

    task automatic pulse(input logic [11:0] v, input bit lat, input logic [11:0] expv,
                         input bit ack_salida);
        @(negedge clock);
        datos = v;
        ready = 1'b1;
        $display("sample %h", v);
        @(negedge clock);
        if (lat) chk1("lat_before", promedio_valido, 1'b0);
        if (ack_salida) promedio_ack = 1'b1;
        @(negedge clock);
        promedio_ack = 1'b0;
        if (lat) begin
            chk1("lat_after", promedio_valido, 1'b1);
            chk12("lat_promedio", promedio, expv);
        end
        @(negedge clock);
        ready = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic do_ack();
        @(negedge clock);
        promedio_ack = 1'b1;
        @(negedge clock);
        promedio_ack = 1'b0;
        $display("ack");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n = 0; habilitar = 0; ready = 1; datos = '0; promedio_ack = 0;
        ready0 = 0; datos0 = '0; ack0 = 0;
        repeat (3) @(negedge clock);
        checking = 1;
        chk12("reset_promedio", promedio, 12'h000);
        chk1("reset_valido", promedio_valido, 1'b0);
        chk1("reset_sobrecarga", sobrecarga, 1'b0);

        // ready high through reset release must not count as a sample
        reset_n = 1;
        repeat (3) @(negedge clock);
        habilitar = 1;
        repeat (2) @(negedge clock);
        ready = 0;
        repeat (3) @(negedge clock);

        pulse(12'd100, 0, '0, 0);
        pulse(12'd200, 0, '0, 0);
        pulse(12'd300, 0, '0, 0);
        pulse(12'd400, 1, 12'd250, 0);

        // floor rounding; ack lands on the result-load cycle
        pulse(12'hFFF, 0, '0, 0);
        pulse(12'hFFF, 0, '0, 0);
        pulse(12'hFFF, 0, '0, 0);
        pulse(12'hFFE, 0, '0, 1);
        chk12("floor_promedio", promedio, 12'hFFE);
        chk1("ack_salida_valido", promedio_valido, 1'b1);
        chk1("ack_salida_no_overrun", sobrecarga, 1'b0);
`ifdef PROMEDIO_MINMAX_EN
        chk12("lit_minimo", minimo, 12'hFFE);
        chk12("lit_maximo", maximo, 12'hFFF);
`endif

        pulse(12'd10, 0, '0, 0);
        pulse(12'd20, 0, '0, 0);
        pulse(12'd30, 0, '0, 0);
        pulse(12'd40, 0, '0, 0);
        chk12("overrun_promedio", promedio, 12'd25);
        chk1("overrun_set", sobrecarga, 1'b1);
        pulse(12'd7, 0, '0, 0);
        pulse(12'd7, 0, '0, 0);
        pulse(12'd7, 0, '0, 0);
        pulse(12'd8, 0, '0, 0);
        chk12("second_overrun_promedio", promedio, 12'd7);
        chk1("overrun_sticky", sobrecarga, 1'b1);
        do_ack();
        @(negedge clock);
        chk1("ack_clears", promedio_valido, 1'b0);

        // partial window discarded by habilitar low
        pulse(12'd1000, 0, '0, 0);
        pulse(12'd1000, 0, '0, 0);
        habilitar = 0;
        repeat (3) @(negedge clock);
        habilitar = 1;
        pulse(12'd4, 0, '0, 0);
        pulse(12'd8, 0, '0, 0);
        pulse(12'd12, 0, '0, 0);
        pulse(12'd16, 1, 12'd10, 0);
        chk1("sticky_after_habilitar", sobrecarga, 1'b1);

        // reset mid-window with a pending result
        pulse(12'd50, 0, '0, 0);
        pulse(12'd60, 0, '0, 0);
        @(negedge clock);
        reset_n = 0;
        @(negedge clock);
        chk12("midreset_promedio", promedio, 12'h000);
        chk1("midreset_valido", promedio_valido, 1'b0);
        chk1("midreset_sobrecarga", sobrecarga, 1'b0);
        reset_n = 1;
        repeat (2) @(negedge clock);

        // single-sample window passes samples straight through
        datos0 = 12'h7FF;
        ready0 = 1;
        @(negedge clock);
        chk1("n1_lat_before", valido0, 1'b0);
        @(negedge clock);
        chk1("n1_valido", valido0, 1'b1);
        chk12("n1_promedio", promedio0, 12'h7FF);
        ready0 = 0;
        repeat (3) @(negedge clock);
        datos0 = 12'h800;
        ready0 = 1;
        repeat (2) @(negedge clock);
        chk12("n1_negative", promedio0, 12'h800);
        chk1("n1_overrun", sob0, 1'b1);
        ready0 = 0;
        repeat (3) @(negedge clock);

        checking = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
